// File: rtl/period_meter.sv
// period_meter: measures the rising-to-rising period and the high time of a
// slow asynchronous square wave, counted in clk_100Mhz cycles. A new pair of
// results is published on each rising edge after the first one, with a
// one-cycle period_valid pulse. The timeout level is raised when no rising
// edge arrives within TIMEOUT cycles.
module period_meter #(
    parameter int CNT_W   = 28,
    parameter int TIMEOUT = 250_000_000
) (
    input  logic             clk_100Mhz,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             clear,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             timeout
);

    // The counter stops at TIMEOUT-1, so it can only avoid wrapping if
    // TIMEOUT fits in CNT_W bits.
    if ((TIMEOUT < 1) || (longint'(TIMEOUT) >= (longint'(1) << CNT_W))) begin : g_bad_timeout
        $error("period_meter: TIMEOUT must be in 1 .. 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_IDLE    = 1'b0,  // no reference rising edge yet
        ST_MEASURE = 1'b1   // counting from the last rising edge
    } state_t;

    // Synchronizer and edge-history flops
    logic sync1_q, sync2_q, hist_q;
    logic rise_det, fall_det;

    // Measurement state
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             period_valid_q, period_valid_d;
    logic             timeout_q, timeout_d;

    // Two-flop synchronizer plus history flop; clear deliberately has no effect here.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign rise_det = sync2_q & ~hist_q;
    assign fall_det = ~sync2_q & hist_q;

    // Next-state logic: clear wins over everything, a rising edge wins over timeout.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hi_cap_d       = hi_cap_q;
        period_d       = period_q;
        high_time_d    = high_time_q;
        period_valid_d = 1'b0;
        timeout_d      = timeout_q;

        if (clear) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            hi_cap_d    = '0;
            period_d    = '0;
            high_time_d = '0;
            timeout_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // First rising edge only establishes the reference point.
                    cnt_d = '0;
                    if (rise_det) begin
                        state_d = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (rise_det) begin
                        // cnt counts cycles since the last rise minus one.
                        period_d       = cnt_q + CNT_ONE;
                        high_time_d    = hi_cap_q;
                        cnt_d          = '0;
                        period_valid_d = 1'b1;
                        timeout_d      = 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        // Results keep their last values; wait for a fresh reference.
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (fall_det) begin
                            hi_cap_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Measurement FSM registers with registered outputs.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            hi_cap_q       <= '0;
            period_q       <= '0;
            high_time_q    <= '0;
            period_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            hi_cap_q       <= hi_cap_d;
            period_q       <= period_d;
            high_time_q    <= high_time_d;
            period_valid_q <= period_valid_d;
            timeout_q      <= timeout_d;
        end
    end

    assign period       = period_q;
    assign high_time    = high_time_q;
    assign period_valid = period_valid_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed stimulus for period_meter with a scoreboard.
// Stimulus pushes the expected {period, high_time} pair at each rising edge
// that should publish a result; a monitor pops and compares on every
// period_valid pulse.
module tb_period_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1000;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             sig_in = 1'b0;
    logic             clear  = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             timeout;

    period_meter #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_100Mhz  (clk),
        .rst_n       (rst_n),
        .sig_in      (sig_in),
        .clear       (clear),
        .period      (period),
        .high_time   (high_time),
        .period_valid(period_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CNT_W-1:0] p;
        logic [CNT_W-1:0] h;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Stimulus bookkeeping: the wave in progress is published at the next rise.
    bit armed  = 1'b0;
    int prev_n = 0;
    int prev_h = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end else begin
            $display("ok   %s: %0d (t=%0t)", name, act, $time);
        end
    endtask

    // Monitor: every period_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (period_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: period %0d high_time %0d, required no pulse (t=%0t)",
                         period, high_time, $time);
            end else begin
                e = exp_q.pop_front();
                check("sb_period", 32'(period), 32'(e.p));
                check("sb_high_time", 32'(high_time), 32'(e.h));
                check("sb_timeout_clear", 32'(timeout), 32'd0);
            end
        end
    end

    task automatic push_prev();
        if (armed) begin
            exp_q.push_back('{p: CNT_W'(prev_n), h: CNT_W'(prev_h)});
        end
    endtask

    // One full square-wave period starting with a rise: h cycles high, n-h low.
    task automatic wave(input int n, input int h);
        push_prev();
        armed  = 1'b1;
        prev_n = n;
        prev_h = h;
        sig_in = 1'b1;
        repeat (h) @(negedge clk);
        sig_in = 1'b0;
        repeat (n - h) @(negedge clk);
    endtask

    // Closing rise that publishes the last full wave, then a short pulse.
    task automatic last_rise();
        push_prev();
        armed  = 1'b0;
        sig_in = 1'b1;
        repeat (10) @(negedge clk);
        sig_in = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic do_clear();
        sig_in = 1'b0;
        repeat (4) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        armed = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int k;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_period", 32'(period), 32'd0);
        check("reset_high_time", 32'(high_time), 32'd0);
        check("reset_valid", 32'(period_valid), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Steady 200/100 wave: first rise only arms
        do_clear();
        wave(200, 100);
        wave(200, 100);
        wave(200, 100);
        last_rise();
        check("steady_timeout", 32'(timeout), 32'd0);

        // Switch from 300/30 to 150/120
        do_clear();
        wave(300, 30);
        wave(300, 30);
        wave(150, 120);
        wave(150, 120);
        last_rise();
        check("switch_period", 32'(period), 32'd150);
        check("switch_high_time", 32'(high_time), 32'd120);

        // Timeout: signal stuck high after a valid rise
        do_clear();
        wave(200, 100);
        wave(200, 100);
        push_prev();
        armed  = 1'b0;
        sig_in = 1'b1;
        k = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk);
            if (timeout) begin
                k = i;
                break;
            end
        end
        // rise_det acts on the third clock edge after the drive; timeout 1000 edges later.
        check("timeout_latency", 32'(k), 32'd1003);
        check("timeout_period_kept", 32'(period), 32'd200);
        check("timeout_high_kept", 32'(high_time), 32'd100);
        sig_in = 1'b0;
        repeat (50) @(negedge clk);
        wave(200, 80);
        check("timeout_after_rearm", 32'(timeout), 32'd1);
        wave(200, 80);
        check("timeout_cleared", 32'(timeout), 32'd0);
        armed = 1'b0;

        // Clear coincident with rise_det
        do_clear();
        wave(300, 100);
        wave(300, 100);
        armed  = 1'b0;
        sig_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_period", 32'(period), 32'd0);
        check("clear_high_time", 32'(high_time), 32'd0);
        check("clear_valid", 32'(period_valid), 32'd0);
        check("clear_timeout", 32'(timeout), 32'd0);
        repeat (97) @(negedge clk);
        sig_in = 1'b0;
        repeat (200) @(negedge clk);
        wave(200, 50);
        wave(200, 50);
        last_rise();

        // Asynchronous reset mid-measurement, then period == TIMEOUT edge case
        do_clear();
        wave(1000, 500);
        push_prev();
        armed  = 1'b0;
        sig_in = 1'b1;
        repeat (500) @(negedge clk);
        sig_in = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("async_rst_period", 32'(period), 32'd0);
        check("async_rst_high_time", 32'(high_time), 32'd0);
        check("async_rst_valid", 32'(period_valid), 32'd0);
        check("async_rst_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (500) @(negedge clk);
        wave(1000, 500);
        wave(1000, 400);
        last_rise();
        check("edge_at_limit_period", 32'(period), 32'd1000);
        check("edge_at_limit_timeout", 32'(timeout), 32'd0);

        repeat (20) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
